// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Purpose  : PCSrc codes, op_class encodings and FSM state type shared by the
//            PC sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam logic [2:0] PCS_PLUS4  = 3'b000;
    localparam logic [2:0] PCS_BRANCH = 3'b001;
    localparam logic [2:0] PCS_JUMP   = 3'b010;
    localparam logic [2:0] PCS_REG    = 3'b011;
    localparam logic [2:0] PCS_ILLOP  = 3'b100;
    localparam logic [2:0] PCS_XADR   = 3'b101;
    localparam logic [2:0] PCS_HOLD   = 3'b111;

    localparam logic [2:0] OP_SEQ     = 3'd0;
    localparam logic [2:0] OP_BRANCH  = 3'd1;
    localparam logic [2:0] OP_JUMP    = 3'd2;
    localparam logic [2:0] OP_JR      = 3'd3;
    localparam logic [2:0] OP_ILLEGAL = 3'd4;
    localparam logic [2:0] OP_ERET    = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_ENTER    = 2'd1,
        ST_REDIRECT = 2'd2
    } seq_state_e;

    // Encodings 6 and 7 are unassigned and trap like the explicit illegal op.
    function automatic logic is_illegal(input logic [2:0] op);
        return (op == OP_ILLEGAL) || (op[2:1] == 2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_ctrl_if
// Purpose  : Decoder-side inputs and PC-unit-side outputs of pc_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_seq_ctrl_if #(
    parameter int IRQ_LINES = 4
);
    logic                 stall;
    logic [2:0]           op_class;
    logic                 kernel;
    logic [IRQ_LINES-1:0] irq;
    logic [2:0]           pc_src;
    logic                 epc_we;
    logic [IRQ_LINES-1:0] irq_ack;
    logic                 irq_active;
    logic                 wdt_fire;

    modport master (
        output stall, op_class, kernel, irq,
        input  pc_src, epc_we, irq_ack, irq_active, wdt_fire
    );

    modport slave (
        input  stall, op_class, kernel, irq,
        output pc_src, epc_we, irq_ack, irq_active, wdt_fire
    );
endinterface
`default_nettype wire

// File: rtl/pc_seq_ctrl_irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_enc
// Purpose  : Sticky interrupt pending register with lowest-index-wins
//            one-hot priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_enc
    import pc_seq_pkg::*;
#(
    parameter int IRQ_LINES = 4
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic [IRQ_LINES-1:0] i_irq,
    input  wire logic [IRQ_LINES-1:0] i_clr,
    output logic      [IRQ_LINES-1:0] o_onehot,
    output logic                      o_valid
);
    logic [IRQ_LINES-1:0] r_pend_q;
    logic [IRQ_LINES-1:0] w_pend_d;
    logic                 w_found;

    // A line still held high re-arms its bit even in the cycle it is acked.
    always_comb begin
        w_pend_d = (r_pend_q & ~i_clr) | i_irq;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_q <= '0;
        end else begin
            r_pend_q <= w_pend_d;
        end
    end

    always_comb begin
        o_onehot = '0;
        w_found  = 1'b0;
        for (int i = 0; i < IRQ_LINES; i++) begin
            if (r_pend_q[i] && !w_found) begin
                o_onehot[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    assign o_valid = |r_pend_q;

endmodule
`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_ctrl
// Purpose  : Chooses the PCSrc code each cycle; handles illegal-op traps and
//            two-cycle interrupt entry. Optional stall watchdog enabled by
//            defining PC_SEQ_STALL_WDT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int IRQ_LINES   = 4,
    parameter int STALL_LIMIT = 1024
) (
    input  wire logic   clk,
    input  wire logic   reset,
    pc_seq_ctrl_if.slave bus
);
    if (IRQ_LINES < 1 || IRQ_LINES > 8 || STALL_LIMIT < 2) begin : g_param_check
        $error("pc_seq_ctrl: parameter out of range");
    end

    seq_state_e           r_state_q, w_state_d;
    logic [IRQ_LINES-1:0] r_winner_q, w_winner_d;
    logic [IRQ_LINES-1:0] w_pend_onehot;
    logic                 w_pend_valid;
    logic [IRQ_LINES-1:0] w_ack;
    logic [2:0]           w_pc_src;
    logic                 w_epc_we;
    logic                 w_wdt_fire;
    logic                 w_wdt_expired;

    irq_prio_enc #(
        .IRQ_LINES (IRQ_LINES)
    ) u_prio (
        .clk      (clk),
        .reset    (reset),
        .i_irq    (bus.irq),
        .i_clr    (w_ack),
        .o_onehot (w_pend_onehot),
        .o_valid  (w_pend_valid)
    );

`ifdef PC_SEQ_STALL_WDT_EN
    localparam int WDT_W = $clog2(STALL_LIMIT + 1);
    localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(STALL_LIMIT);

    logic [WDT_W-1:0] r_wdt_cnt_q, w_wdt_cnt_d;

    // Counter only advances in RUN, so it can only expire while in RUN.
    assign w_wdt_expired = (r_state_q == ST_RUN) && (r_wdt_cnt_q == WDT_LIMIT);

    always_comb begin
        w_wdt_cnt_d = r_wdt_cnt_q;
        if (w_wdt_expired || !bus.stall) begin
            w_wdt_cnt_d = '0;
        end else if (r_state_q == ST_RUN) begin
            w_wdt_cnt_d = r_wdt_cnt_q + WDT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdt_cnt_q <= '0;
        end else begin
            r_wdt_cnt_q <= w_wdt_cnt_d;
        end
    end
`else
    assign w_wdt_expired = 1'b0;
`endif

    always_comb begin
        w_state_d  = r_state_q;
        w_winner_d = r_winner_q;
        w_pc_src   = PCS_HOLD;
        w_epc_we   = 1'b0;
        w_ack      = '0;
        w_wdt_fire = 1'b0;
        case (r_state_q)
            ST_RUN: begin
                if (w_wdt_expired) begin
                    w_pc_src   = PCS_ILLOP;
                    w_epc_we   = 1'b1;
                    w_wdt_fire = 1'b1;
                end else if (!bus.stall) begin
                    if (is_illegal(bus.op_class)) begin
                        w_pc_src = PCS_ILLOP;
                        w_epc_we = 1'b1;
                    end else if (!bus.kernel && w_pend_valid) begin
                        // PC holds this cycle; EPC captures it during ENTER.
                        w_winner_d = w_pend_onehot;
                        w_state_d  = ST_ENTER;
                    end else if (bus.op_class == OP_ERET) begin
                        w_pc_src = PCS_REG;
                    end else begin
                        w_pc_src = bus.op_class;
                    end
                end
            end
            ST_ENTER: begin
                if (!bus.stall) begin
                    w_epc_we  = 1'b1;
                    w_ack     = r_winner_q;
                    w_state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (!bus.stall) begin
                    w_pc_src  = PCS_XADR;
                    w_state_d = ST_RUN;
                end
            end
            default: begin
                w_state_d = ST_RUN;
            end
        endcase
        if (reset) begin
            w_pc_src   = PCS_HOLD;
            w_epc_we   = 1'b0;
            w_ack      = '0;
            w_wdt_fire = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= ST_RUN;
            r_winner_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_winner_q <= w_winner_d;
        end
    end

    assign bus.pc_src     = w_pc_src;
    assign bus.epc_we     = w_epc_we;
    assign bus.irq_ack    = w_ack;
    assign bus.irq_active = !reset && (r_state_q != ST_RUN);
    assign bus.wdt_fire   = w_wdt_fire;

endmodule
`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_seq_ctrl
// Purpose  : Directed self-checking bench for pc_seq_ctrl with a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_seq_ctrl;
    localparam int NL  = 4;
    localparam int LIM = 4;
`ifdef PC_SEQ_STALL_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_seq_ctrl_if #(.IRQ_LINES(NL)) bus ();

    pc_seq_ctrl #(.IRQ_LINES(NL), .STALL_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int lowest(input logic [NL-1:0] p);
        for (int i = 0; i < NL; i++) if (p[i]) return i;
        return 0;
    endfunction

    // Behavioural model: mode 0 = running, 1 = entering, 2 = redirecting.
    int             m_mode = 0;
    int             m_win  = 0;
    int             m_cnt  = 0;
    logic [NL-1:0]  m_pend = '0;
    logic [2:0]     e_src;
    logic [NL-1:0]  e_ack;
    logic           e_epc, e_wdt, e_act;
    int             n_mode;

    always @(negedge clk) begin
        e_src = 3'b111; e_epc = 1'b0; e_ack = '0; e_wdt = 1'b0; e_act = 1'b0;
        if (reset) begin
            m_mode = 0; m_pend = '0; m_win = 0; m_cnt = 0;
        end else begin
            e_act  = (m_mode != 0);
            n_mode = m_mode;
            if (m_mode == 0) begin
                if (WDT_ON && m_cnt == LIM) begin
                    e_src = 3'b100; e_epc = 1'b1; e_wdt = 1'b1; m_cnt = 0;
                end else if (bus.stall) begin
                    m_cnt = m_cnt + 1;
                end else begin
                    m_cnt = 0;
                    if (bus.op_class == 4 || bus.op_class >= 6) begin
                        e_src = 3'b100; e_epc = 1'b1;
                    end else if (!bus.kernel && m_pend != 0) begin
                        m_win = lowest(m_pend); n_mode = 1;
                    end else begin
                        e_src = (bus.op_class == 5) ? 3'b011 : bus.op_class;
                    end
                end
            end else if (!bus.stall) begin
                m_cnt = 0;
                if (m_mode == 1) begin
                    e_epc = 1'b1; e_ack = NL'(1 << m_win); n_mode = 2;
                end else begin
                    e_src = 3'b101; n_mode = 0;
                end
            end
            m_pend = (m_pend & ~e_ack) | bus.irq;
            m_mode = n_mode;
        end
        check("pc_src", 32'(bus.pc_src), 32'(e_src));
        check("epc_we", 32'(bus.epc_we), 32'(e_epc));
        check("irq_ack", 32'(bus.irq_ack), 32'(e_ack));
        check("irq_active", 32'(bus.irq_active), 32'(e_act));
        check("wdt_fire", 32'(bus.wdt_fire), 32'(e_wdt));
    end

    task automatic step(input logic r, input logic s, input logic [2:0] op,
                        input logic k, input logic [NL-1:0] q);
        @(posedge clk);
        #1;
        reset = r; bus.stall = s; bus.op_class = op; bus.kernel = k; bus.irq = q;
        #2;
    endtask

    int ep_cnt;

    initial begin
        reset = 1'b1; bus.stall = 1'b0; bus.op_class = 3'd0; bus.kernel = 1'b0; bus.irq = '0;
        step(1, 0, 0, 0, 4'b0000);
        check("rst_pc_src", 32'(bus.pc_src), 32'h7);
        check("rst_active", 32'(bus.irq_active), 32'h0);
        step(1, 0, 0, 0, 4'b0000);

        step(0, 0, 0, 0, 4'b0000);
        check("seq_pc_src", 32'(bus.pc_src), 32'h0);
        step(0, 0, 1, 0, 4'b0000);
        step(0, 0, 2, 0, 4'b0000);
        check("jump_pc_src", 32'(bus.pc_src), 32'h2);
        step(0, 0, 3, 0, 4'b0000);
        step(0, 0, 5, 1, 4'b0000);
        check("eret_pc_src", 32'(bus.pc_src), 32'h3);

        // Two lines rise together; lowest wins, the other follows.
        step(0, 0, 0, 0, 4'b0110);
        check("pulse_t_pc_src", 32'(bus.pc_src), 32'h0);
        step(0, 0, 0, 0, 4'b0000);
        check("take_pc_src", 32'(bus.pc_src), 32'h7);
        step(0, 0, 0, 0, 4'b0000);
        check("enter_ack", 32'(bus.irq_ack), 32'h2);
        check("enter_epc", 32'(bus.epc_we), 32'h1);
        step(0, 0, 0, 0, 4'b0000);
        check("redirect_pc_src", 32'(bus.pc_src), 32'h5);
        step(0, 0, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b0000);
        check("second_ack", 32'(bus.irq_ack), 32'h4);
        step(0, 0, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b0000);

        // Illegal op wins over a simultaneous request.
        step(0, 0, 4, 0, 4'b0001);
        check("illop_pc_src", 32'(bus.pc_src), 32'h4);
        check("illop_epc", 32'(bus.epc_we), 32'h1);
        step(0, 0, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b0000);
        check("after_illop_ack", 32'(bus.irq_ack), 32'h1);
        step(0, 0, 0, 0, 4'b0000);
        step(0, 0, 6, 0, 4'b0000);
        step(0, 0, 7, 0, 4'b0000);
        check("op7_pc_src", 32'(bus.pc_src), 32'h4);

        // Kernel mode masks the take but not the accumulation.
        repeat (10) step(0, 0, 0, 1, 4'b1000);
        check("kernel_no_ack", 32'(bus.irq_ack), 32'h0);
        step(0, 0, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b0000);
        check("kernel_drop_ack", 32'(bus.irq_ack), 32'h8);
        step(0, 0, 0, 0, 4'b0000);

        // Stall across ENTER and REDIRECT.
        step(0, 0, 0, 0, 4'b0010);
        step(0, 0, 0, 0, 4'b0000);
        ep_cnt = 0;
        repeat (3) begin
            step(0, 1, 0, 0, 4'b0000);
            ep_cnt += int'(bus.epc_we);
        end
        step(0, 0, 0, 0, 4'b0000);
        ep_cnt += int'(bus.epc_we);
        check("stall_enter_ack", 32'(bus.irq_ack), 32'h2);
        step(0, 1, 0, 0, 4'b0000);
        ep_cnt += int'(bus.epc_we);
        check("redirect_hold", 32'(bus.pc_src), 32'h7);
        check("epc_once", 32'(ep_cnt), 32'h1);
        step(0, 0, 0, 0, 4'b0000);
        check("redirect_late", 32'(bus.pc_src), 32'h5);
        step(0, 0, 0, 0, 4'b0000);

        // Long stall in RUN.
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 0, 0, 4'b0000);
            if (WDT_ON && i == 5) begin
                check("wdt_fire_5", 32'(bus.wdt_fire), 32'h1);
                check("wdt_pc_src_5", 32'(bus.pc_src), 32'h4);
            end else begin
                check("stall_hold", 32'(bus.pc_src), 32'h7);
                check("stall_no_wdt", 32'(bus.wdt_fire), 32'h0);
            end
        end
        step(0, 0, 0, 0, 4'b0000);

        // Reset while in ENTER clears everything.
        step(0, 0, 0, 0, 4'b1000);
        step(0, 0, 0, 0, 4'b0000);
        step(1, 0, 0, 0, 4'b0000);
        check("rst_enter_pc_src", 32'(bus.pc_src), 32'h7);
        check("rst_enter_ack", 32'(bus.irq_ack), 32'h0);
        check("rst_enter_active", 32'(bus.irq_active), 32'h0);
        step(0, 0, 0, 0, 4'b0000);
        check("post_rst_active", 32'(bus.irq_active), 32'h0);
        check("post_rst_pc_src", 32'(bus.pc_src), 32'h0);
        step(0, 0, 0, 0, 4'b0000);
        check("post_rst_no_ack", 32'(bus.irq_ack), 32'h0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Sequencing controller for the PC update unit: every cycle it decides the 3-bit `PCSrc` code that selects the next PC (sequential, branch, jump, register jump, illegal-op vector, interrupt vector, hold). It tracks pending interrupt requests, performs the two-cycle interrupt entry with EPC capture, and sends illegal opcodes to the exception vector. It sits between the instruction decoder and the PC register, alongside the control unit.

## Interface
- `IRQ_LINES`, 4: number of level-sensitive interrupt request lines, 1..8.
- `STALL_LIMIT`, 1024: consecutive-stall threshold for the watchdog, ≥2; counter width `$clog2(STALL_LIMIT+1)`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: pipeline stall; PC must hold.
- `op_class` in 3: decoded current instruction: 0 seq, 1 cond branch, 2 jump, 3 jump-register, 4 illegal, 5 eret, 6/7 treated as illegal.
- `kernel` in 1: current PC[31]; 1 = handler/kernel mode.
- `irq` in IRQ_LINES: interrupt requests.
- `pc_src` out 3: PCSrc code to the PC unit.
- `epc_we` out 1: write-enable for EPC capture of plus4.
- `irq_ack` out IRQ_LINES: one-hot, one-cycle acknowledge.
- `irq_active` out 1: interrupt entry in progress (state ≠ RUN).
- `wdt_fire` out 1: stall-watchdog pulse (only with macro).

## Operation
- PCSrc codes: 000 plus4, 001 cond branch, 010 jump, 011 register (A), 100 ILLOP vector, 101 XADR vector, 111 hold.
- FSM states: RUN, ENTER, REDIRECT.
- RUN, stall=1: pc_src=111, epc_we=0.
- RUN, stall=0, op_class 0..3: pc_src = op_class (3'b0xx), combinational.
- RUN, stall=0, op_class ∈ {4,6,7}: pc_src=100 and epc_we=1 in the same cycle; state stays RUN.
- RUN, stall=0, op_class=5: pc_src=011 (EPC is presented on A).
- Pending register `pend[IRQ_LINES-1:0]`: `pend |= irq` every cycle. The acknowledged bit clears in the cycle of its ack. Lines are level-sensitive: a line still held high re-sets its bit afterwards.
- Interrupt take: in RUN with stall=0, kernel=0, pend≠0 and op_class not illegal → register winner = lowest-index pending bit; pc_src=111 this cycle; next state ENTER.
- Priority: illegal > interrupt > normal flow.
- ENTER: epc_we=1, irq_ack=winner one-hot, pc_src=111 → REDIRECT. If stall=1: stay in ENTER, epc_we=0, irq_ack=0.
- REDIRECT: pc_src=101 → RUN. If stall=1: hold with pc_src=111.
- kernel=1 masks taking interrupts; requests still accumulate in pend.
- Reset (any cycle, any state): state←RUN, pend←0, winner←0, watchdog←0.
- While reset is high: pc_src=111, epc_we=0, irq_ack=0, irq_active=0, wdt_fire=0.
- First cycle after reset: state RUN, outputs follow the RUN rules.

## Timing
- Illegal redirect latency: 0 cycles (same cycle).
- Interrupt latency:
  - cycle t: irq sampled (taken if RUN, unstalled, kernel=0); pend set at t+1.
  - t+1: take decision.
  - t+2: ENTER (epc_we, ack).
  - t+3: REDIRECT (pc_src=101).
  - Minimum 3 cycles from irq rise to pc_src=101, excluding stalls.
- irq_ack and epc_we are asserted in the same single cycle only.
- Simultaneous irq rise and illegal op: illegal is handled first; the interrupt stays pending.

## Configuration
- `PC_SEQ_STALL_WDT_EN` defined:
  - counter increments each RUN cycle with stall=1 and clears on stall=0.
  - When the counter reaches STALL_LIMIT, next cycle: pc_src=100, epc_we=1, wdt_fire=1 for one cycle (overriding stall); counter clears.
- Not defined: no counter; wdt_fire tied to 0; stall holds indefinitely.

## Structure
- Package `pc_seq_pkg`: PCSrc code localparams (PCS_PLUS4 … PCS_HOLD), op_class encodings, FSM state enum.
- Sub-module `irq_prio_enc`: pending register plus lowest-index priority encoder, with one-hot output and a valid flag.

## Test plan
- Reset held mid-ENTER with stall=0 → next cycle state RUN, irq_ack=0, pend=0; pc_src=111 during reset.
- irq=4'b0110 pulse 1 cycle, kernel=0, op_class=0 → irq_ack=4'b0010 at t+2 with epc_we=1; pc_src=101 at t+3; line 2 is acked on the next entry.
- op_class=4 with irq[0]=1 in the same cycle → pc_src=100, epc_we=1 immediately; interrupt entry follows, ack=0001.
- kernel=1, irq[3]=1 for 10 cycles → no ack. kernel drops → ack=1000 two cycles later.
- stall=1 for 3 cycles during ENTER → epc_we/irq_ack asserted once, in the first unstalled cycle.
- Macro on, STALL_LIMIT=4, stall held 6 cycles → wdt_fire and pc_src=100 on the 5th cycle, then 111.
